// File: rtl/cache_fill_pkg.sv
// Shared types and default geometry for the critical-word-first line-fill engine.
package cache_fill_pkg;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      RESP  = 2'd2
   } fill_state_t;

   localparam int DEF_ADDR_W     = 32;
   localparam int DEF_DATA_W     = 32;
   localparam int DEF_LINE_WORDS = 4;
endpackage

// File: rtl/line_buf.sv
// Line storage: one word written per cycle at an index, whole line read out flat.
module line_buf
   import cache_fill_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int LINE_WORDS = DEF_LINE_WORDS,
   localparam int IDX_W     = $clog2(LINE_WORDS)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         wr_en,
   input  logic [IDX_W-1:0]             wr_idx,
   input  logic [DATA_W-1:0]            wr_data,
   output logic [LINE_WORDS*DATA_W-1:0] line
);

   logic [DATA_W-1:0] words_r [LINE_WORDS];

   // word storage, cleared by reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < LINE_WORDS; i++) begin
            words_r[i] <= '0;
         end
      end else if (wr_en) begin
         words_r[wr_idx] <= wr_data;
      end
   end

   // flatten: word i occupies bits [i*DATA_W +: DATA_W]
   always_comb begin
      line = '0;
      for (int i = 0; i < LINE_WORDS; i++) begin
         line[i*DATA_W +: DATA_W] = words_r[i];
      end
   end

endmodule

// File: rtl/cache_line_fill.sv
// Critical-word-first cache line fill: fetches LINE_WORDS words starting at the
// missed word, wrapping within the line, then presents the whole line.
module cache_line_fill
   import cache_fill_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int LINE_WORDS = DEF_LINE_WORDS
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         fill_req_valid,
   output logic                         fill_req_ready,
   input  logic [ADDR_W-1:0]            fill_req_addr,
   output logic                         fill_crit_valid,
   output logic [DATA_W-1:0]            fill_crit_data,
   output logic                         fill_rsp_valid,
   input  logic                         fill_rsp_ready,
   output logic [ADDR_W-1:0]            fill_rsp_addr,
   output logic [LINE_WORDS*DATA_W-1:0] fill_rsp_data,
   output logic                         fill_rsp_err,
   output logic                         mem_rd_req,
   output logic [ADDR_W-1:0]            mem_rd_addr,
   input  logic                         mem_rd_ack,
   input  logic [DATA_W-1:0]            mem_rd_data,
   input  logic                         mem_rd_err
);

   localparam int IDX_W  = $clog2(LINE_WORDS);
   localparam int BYTE_W = $clog2(DATA_W / 8);
   localparam int OFF_W  = $clog2(LINE_WORDS * DATA_W / 8);
   localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);
   localparam logic [IDX_W-1:0]  LAST_CNT = IDX_W'(LINE_WORDS - 1);

   fill_state_t       state_r, state_n;
   logic [ADDR_W-1:0] base_r;
   logic [IDX_W-1:0]  idx_r, cnt_r;
   logic              err_r, ready_r, req_r, rsp_valid_r, crit_valid_r;
   logic [DATA_W-1:0] crit_data_r;
   logic              accept_s, ack_s;

   // next-state decode; ready is gated by its register so the first cycle after reset accepts nothing
   always_comb begin
      state_n  = state_r;
      accept_s = 1'b0;
      ack_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (fill_req_valid && ready_r) begin
               accept_s = 1'b1;
               state_n  = FETCH;
            end else begin
               state_n = IDLE;
            end
         end
         FETCH: begin
            if (mem_rd_ack) begin
               ack_s = 1'b1;
               if (cnt_r == LAST_CNT) begin
                  state_n = RESP;
               end else begin
                  state_n = FETCH;
               end
            end else begin
               state_n = FETCH;
            end
         end
         RESP: begin
            if (fill_rsp_ready) begin
               state_n = IDLE;
            end else begin
               state_n = RESP;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // state, registered handshake outputs, index/counter/error tracking
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         ready_r      <= 1'b0;
         req_r        <= 1'b0;
         rsp_valid_r  <= 1'b0;
         crit_valid_r <= 1'b0;
         crit_data_r  <= '0;
         base_r       <= '0;
         idx_r        <= '0;
         cnt_r        <= '0;
         err_r        <= 1'b0;
      end else begin
         state_r      <= state_n;
         ready_r      <= (state_n == IDLE);
         req_r        <= (state_n == FETCH);
         rsp_valid_r  <= (state_n == RESP);
         crit_valid_r <= ack_s && (cnt_r == {IDX_W{1'b0}});
         if (ack_s && (cnt_r == {IDX_W{1'b0}})) begin
            crit_data_r <= mem_rd_data;
         end
         if (accept_s) begin
            base_r <= fill_req_addr & ~OFF_MASK;
            idx_r  <= fill_req_addr[OFF_W-1:BYTE_W];
            cnt_r  <= {IDX_W{1'b0}};
            err_r  <= 1'b0;
         end else if (ack_s) begin
            idx_r  <= idx_r + IDX_W'(1);
            cnt_r  <= cnt_r + IDX_W'(1);
            err_r  <= err_r | mem_rd_err;
         end
      end
   end

   line_buf #(
      .DATA_W     (DATA_W),
      .LINE_WORDS (LINE_WORDS)
   ) u_line_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (ack_s),
      .wr_idx  (idx_r),
      .wr_data (mem_rd_data),
      .line    (fill_rsp_data)
   );

   assign fill_req_ready  = ready_r;
   assign fill_crit_valid = crit_valid_r;
   assign fill_crit_data  = crit_data_r;
   assign fill_rsp_valid  = rsp_valid_r;
   assign fill_rsp_addr   = base_r;
   assign fill_rsp_err    = err_r;
   assign mem_rd_req      = req_r;
   assign mem_rd_addr     = base_r + (ADDR_W'(idx_r) << BYTE_W);

endmodule

// File: tb/tb_cache_line_fill.sv
// Directed bench for cache_line_fill with a latency-configurable memory responder.
module tb_cache_line_fill;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         fill_req_valid, fill_req_ready;
   logic [31:0]  fill_req_addr;
   logic         fill_crit_valid;
   logic [31:0]  fill_crit_data;
   logic         fill_rsp_valid, fill_rsp_ready;
   logic [31:0]  fill_rsp_addr;
   logic [127:0] fill_rsp_data;
   logic         fill_rsp_err;
   logic         mem_rd_req;
   logic [31:0]  mem_rd_addr;
   logic         mem_rd_ack;
   logic [31:0]  mem_rd_data;
   logic         mem_rd_err;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // responder configuration and logs
   int          lat_max = 0;
   int          err_ack = 0;
   int          n_acks = 0;
   logic [31:0] dbase = 32'h0;
   logic [31:0] rd_log[$];
   int          addr_unstable = 0;
   int          crit_cnt = 0;
   int          crit_cyc = 0;
   logic [31:0] crit_last = 32'h0;

   cache_line_fill #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .fill_req_valid(fill_req_valid), .fill_req_ready(fill_req_ready), .fill_req_addr(fill_req_addr),
      .fill_crit_valid(fill_crit_valid), .fill_crit_data(fill_crit_data),
      .fill_rsp_valid(fill_rsp_valid), .fill_rsp_ready(fill_rsp_ready), .fill_rsp_addr(fill_rsp_addr),
      .fill_rsp_data(fill_rsp_data), .fill_rsp_err(fill_rsp_err),
      .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_ack(mem_rd_ack),
      .mem_rd_data(mem_rd_data), .mem_rd_err(mem_rd_err)
   );

   always #5 clk = ~clk;

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // memory model: word at addr returns dbase + word-in-line, acked after 0..lat_max cycles
   initial begin
      bit          waiting;
      logic [31:0] wait_addr;
      int          wait_left;
      waiting = 1'b0; wait_addr = 32'h0; wait_left = 0;
      mem_rd_ack = 1'b0; mem_rd_data = 32'h0; mem_rd_err = 1'b0;
      forever begin
         @(negedge clk);
         mem_rd_ack = 1'b0; mem_rd_data = 32'h0; mem_rd_err = 1'b0;
         if (mem_rd_req === 1'b1) begin
            if (!waiting) begin
               waiting   = 1'b1;
               wait_addr = mem_rd_addr;
               wait_left = (lat_max > 0) ? int'($urandom_range(lat_max, 0)) : 0;
            end else if (mem_rd_addr !== wait_addr) begin
               addr_unstable++;
            end
            if (wait_left == 0) begin
               n_acks++;
               mem_rd_ack  = 1'b1;
               mem_rd_data = dbase + {30'd0, mem_rd_addr[3:2]};
               mem_rd_err  = (n_acks == err_ack);
               rd_log.push_back(mem_rd_addr);
               waiting = 1'b0;
            end else begin
               wait_left--;
            end
         end else begin
            waiting = 1'b0;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (fill_crit_valid === 1'b1) begin
            crit_cnt++;
            crit_cyc  = cyc;
            crit_last = fill_crit_data;
         end
      end
   end

   function automatic logic [127:0] exp_line(input logic [31:0] d);
      logic [127:0] l;
      for (int i = 0; i < 4; i++) l[i*32 +: 32] = d + i;
      return l;
   endfunction

   task automatic prep(input logic [31:0] d, input int lat, input int errn);
      dbase = d; lat_max = lat; err_ack = errn;
      n_acks = 0; rd_log.delete(); addr_unstable = 0; crit_cnt = 0;
   endtask

   task automatic start_fill(input logic [31:0] a, output int acc_cyc, output bit ok);
      int k;
      @(negedge clk);
      fill_req_valid = 1'b1; fill_req_addr = a; k = 0;
      while (fill_req_ready !== 1'b1 && k < 100) begin
         @(negedge clk);
         k++;
      end
      ok = (fill_req_ready === 1'b1);
      acc_cyc = cyc;
      @(posedge clk); #1;
      fill_req_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int rsp_cyc, output bit ok);
      int k;
      k = 0;
      @(negedge clk);
      while (fill_rsp_valid !== 1'b1 && k < 200) begin
         @(negedge clk);
         k++;
      end
      ok = (fill_rsp_valid === 1'b1);
      rsp_cyc = cyc;
   endtask

   task automatic consume();
      fill_rsp_ready = 1'b1;
      @(posedge clk); #1;
      fill_rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_tests++;
      if ({fill_req_ready, mem_rd_req, fill_rsp_valid, fill_crit_valid, fill_rsp_err} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b expected 00000",
                  {fill_req_ready, mem_rd_req, fill_rsp_valid, fill_crit_valid, fill_rsp_err});
      end
      n_tests++;
      if ({fill_rsp_addr, fill_rsp_data, mem_rd_addr, fill_crit_data} !== 224'h0) begin
         n_fail++;
         $display("FAIL reset_data: got %h/%h/%h/%h expected all 0",
                  fill_rsp_addr, fill_rsp_data, mem_rd_addr, fill_crit_data);
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_tests++;
      if (fill_req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_ready_rise: got %b expected 1", fill_req_ready);
      end
   endtask

   task automatic test_aligned();
      int acc, rc; bit ok1, ok2;
      prep(32'hA0, 0, 0);
      start_fill(32'h100, acc, ok1);
      wait_rsp(rc, ok2);
      n_tests++;
      if (!ok1 || !ok2) begin n_fail++; $display("FAIL aligned_timeout: got %b%b expected 11", ok1, ok2); end
      n_tests++;
      if (rc - acc != 5) begin n_fail++; $display("FAIL aligned_latency: got %0d expected 5", rc - acc); end
      n_tests++;
      if (rd_log.size() != 4 || rd_log[0] !== 32'h100 || rd_log[1] !== 32'h104 ||
          rd_log[2] !== 32'h108 || rd_log[3] !== 32'h10C) begin
         n_fail++; $display("FAIL aligned_reads: got %p expected 100,104,108,10c", rd_log);
      end
      n_tests++;
      if (fill_rsp_data !== 128'h000000A3_000000A2_000000A1_000000A0) begin
         n_fail++; $display("FAIL aligned_data: got %h expected A3..A0", fill_rsp_data);
      end
      n_tests++;
      if (fill_rsp_addr !== 32'h100 || fill_rsp_err !== 1'b0) begin
         n_fail++; $display("FAIL aligned_addr_err: got %h/%b expected 100/0", fill_rsp_addr, fill_rsp_err);
      end
      n_tests++;
      if (crit_cnt != 1 || crit_last !== 32'hA0 || crit_cyc - acc != 2) begin
         n_fail++; $display("FAIL aligned_crit: got n=%0d d=%h at %0d expected n=1 d=a0 at 2",
                            crit_cnt, crit_last, crit_cyc - acc);
      end
      consume();
      @(negedge clk);
      n_tests++;
      if (fill_rsp_valid !== 1'b0 || fill_req_ready !== 1'b1) begin
         n_fail++; $display("FAIL aligned_release: got v=%b r=%b expected v=0 r=1", fill_rsp_valid, fill_req_ready);
      end
   endtask

   task automatic test_crit_first();
      int acc, rc; bit ok1, ok2;
      prep(32'h1000_0000, 0, 0);
      start_fill(32'h208, acc, ok1);
      wait_rsp(rc, ok2);
      n_tests++;
      if (!ok1 || !ok2 || rd_log.size() != 4 || rd_log[0] !== 32'h208 || rd_log[1] !== 32'h20C ||
          rd_log[2] !== 32'h200 || rd_log[3] !== 32'h204) begin
         n_fail++; $display("FAIL cwf_reads: got %p expected 208,20c,200,204", rd_log);
      end
      n_tests++;
      if (crit_cnt != 1 || crit_last !== 32'h1000_0002) begin
         n_fail++; $display("FAIL cwf_crit: got n=%0d d=%h expected n=1 d=10000002", crit_cnt, crit_last);
      end
      n_tests++;
      if (fill_rsp_addr !== 32'h200 || fill_rsp_data !== exp_line(32'h1000_0000)) begin
         n_fail++; $display("FAIL cwf_rsp: got %h/%h expected 200/%h", fill_rsp_addr, fill_rsp_data,
                            exp_line(32'h1000_0000));
      end
      consume();
   endtask

   task automatic test_latency();
      int acc, rc; bit ok1, ok2, stable;
      logic [127:0] cap_d; logic [31:0] cap_a; logic cap_e;
      prep(32'h5500, 5, 0);
      start_fill(32'h40C, acc, ok1);
      wait_rsp(rc, ok2);
      cap_d = fill_rsp_data; cap_a = fill_rsp_addr; cap_e = fill_rsp_err;
      stable = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (fill_rsp_valid !== 1'b1 || fill_rsp_data !== cap_d || fill_rsp_addr !== cap_a ||
             fill_rsp_err !== cap_e || mem_rd_req !== 1'b0) stable = 1'b0;
      end
      n_tests++;
      if (!ok1 || !ok2 || !stable) begin
         n_fail++; $display("FAIL lat_rsp_stable: got %b%b%b expected 111", ok1, ok2, stable);
      end
      n_tests++;
      if (cap_a !== 32'h400 || cap_d !== exp_line(32'h5500)) begin
         n_fail++; $display("FAIL lat_rsp: got %h/%h expected 400/%h", cap_a, cap_d, exp_line(32'h5500));
      end
      consume();
      repeat (4) @(negedge clk);
      n_tests++;
      if (addr_unstable != 0) begin
         n_fail++; $display("FAIL lat_addr_stable: got %0d changes expected 0", addr_unstable);
      end
      n_tests++;
      if (n_acks != 4 || rd_log.size() != 4 || rd_log[0] !== 32'h40C || rd_log[1] !== 32'h400 ||
          rd_log[2] !== 32'h404 || rd_log[3] !== 32'h408) begin
         n_fail++; $display("FAIL lat_reads: got %0d %p expected 4 40c,400,404,408", n_acks, rd_log);
      end
   endtask

   task automatic test_error();
      int acc, rc; bit ok1, ok2;
      prep(32'hE0, 0, 3);
      start_fill(32'h100, acc, ok1);
      wait_rsp(rc, ok2);
      n_tests++;
      if (!ok1 || !ok2 || fill_rsp_err !== 1'b1 || rd_log.size() != 4 ||
          fill_rsp_data !== exp_line(32'hE0)) begin
         n_fail++; $display("FAIL err_report: got err=%b reads=%0d data=%h expected err=1 reads=4 data=%h",
                            fill_rsp_err, rd_log.size(), fill_rsp_data, exp_line(32'hE0));
      end
      consume();
      prep(32'hF0, 0, 0);
      start_fill(32'h110, acc, ok1);
      wait_rsp(rc, ok2);
      n_tests++;
      if (!ok1 || !ok2 || fill_rsp_err !== 1'b0 || fill_rsp_addr !== 32'h110) begin
         n_fail++; $display("FAIL err_cleared: got err=%b addr=%h expected err=0 addr=110", fill_rsp_err, fill_rsp_addr);
      end
      consume();
   endtask

   task automatic test_reset_mid();
      int acc, rc; bit ok1, ok2, seen;
      prep(32'h4400, 0, 0);
      start_fill(32'h400, acc, ok1);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      n_tests++;
      if (!ok1 || rd_log.size() < 2 || rd_log[1] !== 32'h404) begin
         n_fail++; $display("FAIL rstmid_pre: got %0d reads expected >=2 with 2nd at 404", rd_log.size());
      end
      @(negedge clk);
      n_tests++;
      if (mem_rd_req !== 1'b0 || fill_rsp_valid !== 1'b0) begin
         n_fail++; $display("FAIL rstmid_req_drop: got req=%b v=%b expected 0/0", mem_rd_req, fill_rsp_valid);
      end
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (fill_rsp_valid !== 1'b0 || mem_rd_req !== 1'b0) seen = 1'b1;
      end
      n_tests++;
      if (seen) begin n_fail++; $display("FAIL rstmid_no_rsp: got activity expected none"); end
      prep(32'h3000, 0, 0);
      start_fill(32'h300, acc, ok1);
      wait_rsp(rc, ok2);
      n_tests++;
      if (!ok1 || !ok2 || rc - acc != 5 || fill_rsp_addr !== 32'h300 ||
          fill_rsp_data !== exp_line(32'h3000) || fill_rsp_err !== 1'b0) begin
         n_fail++; $display("FAIL rstmid_refill: got lat=%0d addr=%h data=%h err=%b expected 5/300/%h/0",
                            rc - acc, fill_rsp_addr, fill_rsp_data, fill_rsp_err, exp_line(32'h3000));
      end
      consume();
   endtask

   task automatic test_back_to_back();
      int hs_n, rsp_n;
      int hs_c[2]; int rsp_c[2];
      logic [31:0] rsp_a[2];
      logic [127:0] rsp_d[2];
      hs_n = 0; rsp_n = 0;
      hs_c = '{0, 0}; rsp_c = '{0, 0}; rsp_a = '{32'h0, 32'h0}; rsp_d = '{128'h0, 128'h0};
      prep(32'h7000, 0, 0);
      fill_rsp_ready = 1'b1;
      @(negedge clk);
      fill_req_valid = 1'b1; fill_req_addr = 32'h500;
      for (int k = 0; k < 80 && rsp_n < 2; k++) begin
         if (fill_rsp_valid === 1'b1) begin
            rsp_c[rsp_n] = cyc; rsp_a[rsp_n] = fill_rsp_addr; rsp_d[rsp_n] = fill_rsp_data;
            rsp_n++;
         end
         if (fill_req_valid === 1'b1 && fill_req_ready === 1'b1 && hs_n < 2) begin
            hs_c[hs_n] = cyc;
            hs_n++;
            @(posedge clk); #1;
            if (hs_n == 1) fill_req_addr = 32'h520;
            else fill_req_valid = 1'b0;
         end
         @(negedge clk);
      end
      fill_req_valid = 1'b0;
      fill_rsp_ready = 1'b0;
      n_tests++;
      if (hs_n != 2 || rsp_n != 2) begin
         n_fail++; $display("FAIL b2b_counts: got hs=%0d rsp=%0d expected 2/2", hs_n, rsp_n);
      end
      n_tests++;
      if (hs_c[1] != rsp_c[0] + 1 || rsp_c[0] - hs_c[0] != 5) begin
         n_fail++; $display("FAIL b2b_timing: got accept2-rsp1=%0d rsp1-accept1=%0d expected 1/5",
                            hs_c[1] - rsp_c[0], rsp_c[0] - hs_c[0]);
      end
      n_tests++;
      if (rsp_a[0] !== 32'h500 || rsp_a[1] !== 32'h520 || rsp_d[1] !== exp_line(32'h7000)) begin
         n_fail++; $display("FAIL b2b_rsp: got %h/%h/%h expected 500/520/%h", rsp_a[0], rsp_a[1], rsp_d[1],
                            exp_line(32'h7000));
      end
   endtask

   initial begin
      rst_n = 1'b0; fill_req_valid = 1'b0; fill_req_addr = 32'h0; fill_rsp_ready = 1'b0;
      test_reset();
      test_aligned();
      test_crit_first();
      test_latency();
      test_error();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cache_line_fill.md
CACHE_LINE_FILL -- requirements
Module: cache_line_fill

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width in bits.
REQ-002 SHALL have parameter DATA_W, default 32, memory word width in bits.
REQ-003 SHALL have parameter LINE_WORDS, default 4, words per cache line; must be a power of two and at least 2.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-006 SHALL have port fill_req_valid, input, 1, line-fill request from the read-only cache.
REQ-007 SHALL have port fill_req_ready, output, 1, request accepted when high together with valid.
REQ-008 SHALL have port fill_req_addr, input, ADDR_W, byte address of the missed word.
REQ-009 SHALL have port fill_crit_valid, output, 1, one-cycle pulse indicating the critical word is available.
REQ-010 SHALL have port fill_crit_data, output, DATA_W, the critical (missed) word.
REQ-011 SHALL have port fill_rsp_valid, output, 1, complete line available.
REQ-012 SHALL have port fill_rsp_ready, input, 1, cache consumes the line.
REQ-013 SHALL have port fill_rsp_addr, output, ADDR_W, line-aligned base address.
REQ-014 SHALL have port fill_rsp_data, output, LINE_WORDS*DATA_W, line data; word i sits in bits [i*DATA_W +: DATA_W].
REQ-015 SHALL have port fill_rsp_err, output, 1, at least one word read returned an error.
REQ-016 SHALL have port mem_rd_req, output, 1, word read request to memory.
REQ-017 SHALL have port mem_rd_addr, output, ADDR_W, word-aligned read address.
REQ-018 SHALL have port mem_rd_ack, input, 1, read completes this cycle.
REQ-019 SHALL have ports mem_rd_data (input, DATA_W) and mem_rd_err (input, 1), both valid only when mem_rd_ack is high.

Function
REQ-020 SHALL implement the FSM states IDLE, FETCH and RESP.
REQ-021 SHALL drive fill_req_ready high only in IDLE; a handshake moves the FSM to FETCH.
REQ-022 SHALL, on acceptance, capture the line base (address with the low log2(LINE_WORDS*DATA_W/8) bits cleared), the start word index, and clear the error flag.
REQ-023 SHALL in FETCH hold mem_rd_req high with mem_rd_addr = base + idx*(DATA_W/8), stable until mem_rd_ack.
REQ-024 SHALL treat mem_rd_ack arriving in the same cycle as mem_rd_req as a valid completion; one read is outstanding at most.
REQ-025 SHALL, on each ack, write mem_rd_data into line slot idx, OR mem_rd_err into the error flag, and advance idx modulo LINE_WORDS (critical-word-first, wrapping).
REQ-026 SHALL present the next address in the cycle after an ack, so back-to-back acks sustain one word per cycle.
REQ-027 SHALL pulse fill_crit_valid for exactly one cycle, the cycle after the first ack, with fill_crit_data equal to that word.
REQ-028 SHALL, after LINE_WORDS acks, drop mem_rd_req and enter RESP.
REQ-029 SHALL in RESP hold fill_rsp_valid, fill_rsp_addr, fill_rsp_data and fill_rsp_err stable until fill_rsp_ready, then return to IDLE.
REQ-030 SHALL accept no new request in the cycle of the response handshake; ready rises the following cycle.
REQ-031 SHALL have a latency, with ack every cycle, of: accept at cycle 0, mem reads in cycles 1..LINE_WORDS, fill_rsp_valid first high at cycle LINE_WORDS+1.
REQ-032 SHALL not abort on an error: all words are still fetched and fill_rsp_err is reported.
REQ-033 SHALL ignore mem_rd_ack when it arrives outside FETCH.

Reset
REQ-034 SHALL, while rst_n is low at a clock edge, force the FSM to IDLE and clear the index, counter, error flag and line buffer.
REQ-035 SHALL hold every output at 0 during reset, fill_req_ready included; fill_req_ready goes to 1 on the first cycle after rst_n rises.
REQ-036 SHALL, on reset mid-FETCH or mid-RESP, drop the transaction with no response and deassert mem_rd_req from the next cycle.

Structure
REQ-037 SHALL define the FSM state enum and the default line geometry constants in the shared package cache_fill_pkg.
REQ-038 SHALL place the line storage with indexed word write and flat read-out in one sub-module, line_buf.

Verification
REQ-039 SHALL cover aligned fill: addr 0x100, ack every cycle, data 0xA0..0xA3 -> reads at 0x100, 0x104, 0x108, 0x10C; rsp_data {A3,A2,A1,A0}; rsp_valid at cycle 5; err 0.
REQ-040 SHALL cover critical-word-first: addr 0x208 -> reads at 0x208, 0x20C, 0x200, 0x204; crit_data is the 0x208 word; rsp_addr 0x200.
REQ-041 SHALL cover random ack latency of 0..5 cycles plus rsp_ready held low for 3 cycles -> address stable while waiting; response stable; exactly 4 mem reads.
REQ-042 SHALL cover an error: mem_rd_err on the 3rd ack only -> all 4 words fetched; fill_rsp_err=1; the next fill reports err 0.
REQ-043 SHALL cover reset after the 2nd ack -> no rsp_valid; mem_rd_req low the next cycle; a new fill at 0x300 completes correctly.
REQ-044 SHALL cover back-to-back fills with rsp_ready tied to 1 -> second request accepted the cycle after the response handshake, not earlier.
